// File: rtl/sha256d_nonce_scanner.sv
// ---------------------------------------------------------------------------
// sha256d_nonce_scanner
//
// Drives one external sha256_core through Bitcoin double-SHA256 of an 80-byte
// block header while sweeping the nonce over [nonce_start, nonce_end].
// The first header block (midstate) is hashed once per job. Each nonce then
// takes two core operations: the second header block chained from the
// midstate, and the outer hash of that 256-bit digest from the standard IV.
// The byte-reversed outer digest is compared against a 256-bit target.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   job_valid/ready  job handshake; ready only while idle
//   header[639:0]    header, byte 0 at [639:632]; nonce field (bytes 76..79)
//                    is ignored and replaced by the swept nonce
//   nonce_start/end  inclusive numeric nonce range
//   target[255:0]    hit when hash_num <= target
//   abort            abandon the current scan
//   busy             high from job accept until scan_done
//   found_*          1-cycle found_valid pulse; nonce/hash held until next hit
//   scan_done/hit    1-cycle end-of-scan pulse; scan_hit = any hit this job
//   core_*           start/block/use_iv/iv to the core, done/hash back
//
// Core handshake inside each hashing state:
//   WAIT    start low until the core reports done low (only after accept,
//           so an operation abandoned by reset is fully closed first)
//   ISSUE   start high with stable operands until done; digest captured
//   RELEASE start low until done drops, then move on
// ---------------------------------------------------------------------------
module sha256d_nonce_scanner #(
    parameter bit STOP_ON_FOUND = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [639:0] header,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    input  logic         abort,
    output logic         busy,
    output logic         found_valid,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         scan_done,
    output logic         scan_hit,
    output logic         core_start,
    output logic [511:0] core_block,
    output logic         core_use_iv,
    output logic [255:0] core_iv,
    input  logic         core_done,
    input  logic [255:0] core_hash
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MID,
        S_BLK2,
        S_OUTER,
        S_CHECK,
        S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        PH_WAIT,
        PH_ISSUE,
        PH_RELEASE
    } phase_e;

    // Digest word order: digest byte 0 sits at [255:248]. hash_num puts
    // digest byte 31 in the most significant position.
    function automatic logic [255:0] byte_rev(input logic [255:0] d);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[255-8*i -: 8];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    phase_e phase_q, phase_d;
    logic   abort_pend_q, abort_pend_d;

    // Job data and intermediate digests
    logic [607:0] hdr_q;          // header bytes 0..75
    logic [31:0]  nonce_end_q;
    logic [255:0] target_q;
    logic [31:0]  n_q;
    logic [255:0] midstate_q;
    logic [255:0] blk2_q;
    logic [255:0] hash_num_q;

    // Reported results
    logic         hit_q;
    logic         found_valid_q;
    logic [31:0]  found_nonce_q;
    logic [255:0] found_hash_q;
    logic         scan_done_q;
    logic         scan_hit_q;

    // Strobes from the control logic to the datapath
    logic accept;
    logic capture;
    logic advance;
    logic report_hit;
    logic hash_le_target;

    // The header's own nonce field never reaches the core.
    logic unused_header_nonce;
    assign unused_header_nonce = ^header[31:0];

    assign hash_le_target = (hash_num_q <= target_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        phase_d      = phase_q;
        abort_pend_d = abort_pend_q;
        accept       = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        report_hit   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    accept       = 1'b1;
                    abort_pend_d = 1'b0;
                    phase_d      = PH_WAIT;
                    state_d      = (nonce_start > nonce_end) ? S_FINISH : S_MID;
                end
            end

            S_MID, S_BLK2, S_OUTER: begin
                unique case (phase_q)
                    PH_WAIT: begin
                        // No handshake is open yet, so abort can leave now.
                        if (abort) begin
                            state_d = S_FINISH;
                        end else if (!core_done) begin
                            phase_d = PH_ISSUE;
                        end
                    end

                    PH_ISSUE: begin
                        // An abort during an operation is held until the core
                        // has been released, so the core is never left with
                        // done asserted when the next job starts.
                        if (abort) begin
                            abort_pend_d = 1'b1;
                        end
                        if (core_done) begin
                            capture = 1'b1;
                            phase_d = PH_RELEASE;
                        end
                    end

                    PH_RELEASE: begin
                        if (abort) begin
                            abort_pend_d = 1'b1;
                        end
                        if (!core_done) begin
                            phase_d = PH_ISSUE;
                            if (abort_pend_q || abort) begin
                                state_d = S_FINISH;
                            end else begin
                                unique case (state_q)
                                    S_MID:   state_d = S_BLK2;
                                    S_BLK2:  state_d = S_OUTER;
                                    default: state_d = S_CHECK;
                                endcase
                            end
                        end
                    end

                    default: phase_d = PH_WAIT;
                endcase
            end

            S_CHECK: begin
                report_hit = hash_le_target;
                // The hit (if any) is still reported when abort ends the scan.
                if (abort || (report_hit && STOP_ON_FOUND) || (n_q == nonce_end_q)) begin
                    state_d = S_FINISH;
                end else begin
                    advance = 1'b1;
                    state_d = S_BLK2;
                    phase_d = PH_ISSUE;
                end
            end

            S_FINISH: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_WAIT;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Job data path
    // ------------------------------------------------------------------
    // NOTE: these wide registers carry no reset; they are always written on
    // accept or capture before anything reads them, so a reset would only
    // add fanout on rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            hdr_q       <= header[639:32];
            nonce_end_q <= nonce_end;
            target_q    <= target;
            n_q         <= nonce_start;
        end else if (advance) begin
            n_q <= n_q + 32'd1;
        end

        if (capture) begin
            unique case (state_q)
                S_MID:   midstate_q <= core_hash;
                S_BLK2:  blk2_q     <= core_hash;
                S_OUTER: hash_num_q <= byte_rev(core_hash);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result reporting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q         <= 1'b0;
            found_valid_q <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            scan_done_q   <= 1'b0;
            scan_hit_q    <= 1'b0;
        end else begin
            if (accept) begin
                hit_q <= 1'b0;
            end else if (report_hit) begin
                hit_q <= 1'b1;
            end

            found_valid_q <= report_hit;
            if (report_hit) begin
                found_nonce_q <= n_q;
                found_hash_q  <= hash_num_q;
            end

            // Registered from FINISH, so the pulse lands on the first IDLE
            // cycle, the same cycle busy drops.
            scan_done_q <= (state_q == S_FINISH);
            scan_hit_q  <= (state_q == S_FINISH) && hit_q;
        end
    end

    // ------------------------------------------------------------------
    // Core operands: zero outside the hashing states
    // ------------------------------------------------------------------
    always_comb begin
        core_block  = '0;
        core_use_iv = 1'b0;
        core_iv     = '0;
        unique case (state_q)
            S_MID: begin
                core_block = hdr_q[607:96];
            end
            S_BLK2: begin
                // Header bytes 64..75, little-endian nonce, padding, 640-bit length
                core_block  = {hdr_q[95:0], n_q[7:0], n_q[15:8], n_q[23:16], n_q[31:24],
                               8'h80, 312'd0, 64'd640};
                core_use_iv = 1'b1;
                core_iv     = midstate_q;
            end
            S_OUTER: begin
                // 32-byte digest, padding, 256-bit length
                core_block = {blk2_q, 8'h80, 184'd0, 64'd256};
            end
            default: ;
        endcase
    end

    assign core_start  = (state_q == S_MID || state_q == S_BLK2 || state_q == S_OUTER)
                         && (phase_q == PH_ISSUE);
    assign job_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign found_valid = found_valid_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign scan_done   = scan_done_q;
    assign scan_hit    = scan_hit_q;

endmodule

// File: tb/tb_sha256d_nonce_scanner.sv
// ---------------------------------------------------------------------------
// Bench for sha256d_nonce_scanner. A behavioural sha256_core with a random
// latency answers the scanner's core port. Expected found/done events go
// into a scoreboard queue when a job is issued; a monitor pops and compares
// whenever found_valid or scan_done pulses.
// ---------------------------------------------------------------------------
module tb_sha256d_nonce_scanner;

    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Genesis block header; the nonce field holds junk that must be ignored.
    localparam logic [639:0] GEN_HDR = {
        32'h01000000,
        256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49,
        32'hffff001d,
        32'hdeadbeef
    };
    localparam logic [255:0] GEN_HASH =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TARGET = {32'h00000000, 32'hFFFF0000, 192'h0};
    localparam logic [31:0]  GEN_NONCE  = 32'h7C2BAC1D;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [639:0] header = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] target = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic         found_valid;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         scan_done;
    logic         scan_hit;
    logic         core_start;
    logic [511:0] core_block;
    logic         core_use_iv;
    logic [255:0] core_iv;
    logic         core_done = 1'b0;
    logic [255:0] core_hash = '0;

    always #5 clk = ~clk;

    sha256d_nonce_scanner #(.STOP_ON_FOUND(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .header      (header),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target),
        .abort       (abort),
        .busy        (busy),
        .found_valid (found_valid),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .scan_done   (scan_done),
        .scan_hit    (scan_hit),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_use_iv (core_use_iv),
        .core_iv     (core_iv),
        .core_done   (core_done),
        .core_hash   (core_hash)
    );

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           is_done;
        logic [31:0]  nonce;
        logic [255:0] hash;
        bit           hit;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_found(input logic [31:0] nonce, input logic [255:0] hash);
        exp_t e;
        e.is_done = 1'b0;
        e.nonce   = nonce;
        e.hash    = hash;
        e.hit     = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic push_done(input bit hit);
        exp_t e;
        e.is_done = 1'b1;
        e.nonce   = '0;
        e.hash    = '0;
        e.hit     = hit;
        sb_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Reference SHA-256
    // ------------------------------------------------------------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] iv, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = iv;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + iv[255:224], b + iv[223:192], c + iv[191:160], d + iv[159:128],
                e + iv[127:96],  f + iv[95:64],   g + iv[63:32],   h + iv[31:0]};
    endfunction

    function automatic logic [255:0] byte_rev(input logic [255:0] d);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = d[255-8*i -: 8];
        return r;
    endfunction

    // Bitcoin double hash of an 80-byte header with the given nonce, as a number.
    function automatic logic [255:0] sha256d_ref(input logic [639:0] hdr, input logic [31:0] nonce);
        logic [639:0] msg;
        logic [255:0] st, inner, outer;
        msg   = {hdr[639:32], nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
        st    = sha_compress(H0, msg[639:128]);
        inner = sha_compress(st, {msg[127:0], 8'h80, 312'd0, 64'd640});
        outer = sha_compress(H0, {inner, 8'h80, 184'd0, 64'd256});
        return byte_rev(outer);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural sha256_core: done held until start drops; start dropping
    // mid-operation cancels it.
    // ------------------------------------------------------------------
    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [511:0] m_blk = '0;
    logic [255:0] m_iv = '0;
    int           cnt_start = 0;
    int           cnt_mid = 0;
    int           cnt_blk2 = 0;
    int           cnt_outer = 0;

    always @(posedge clk) begin
        if (m_busy) begin
            if (!core_start) begin
                m_busy <= 1'b0;
            end else if (m_cnt == 0) begin
                core_done <= 1'b1;
                core_hash <= sha_compress(m_iv, m_blk);
                m_busy    <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (core_done) begin
            if (!core_start) core_done <= 1'b0;
        end else if (core_start) begin
            m_busy    <= 1'b1;
            m_cnt     <= int'($urandom_range(0, 4));
            m_blk     <= core_block;
            m_iv      <= core_use_iv ? core_iv : H0;
            cnt_start <= cnt_start + 1;
            if (core_use_iv)                   cnt_blk2  <= cnt_blk2 + 1;
            else if (core_block[63:0] == 64'd256) cnt_outer <= cnt_outer + 1;
            else                               cnt_mid   <= cnt_mid + 1;
        end
    end

    // core_start must only rise while the core reports done low.
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (core_start && !prev_start) check("start_while_done", 256'(core_done), 256'd0);
        prev_start = core_start;
    end

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (found_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_found: nonce=%h hash=%h", found_nonce, found_hash);
                end else begin
                    e = sb_q.pop_front();
                    check("event_kind_found", 256'(e.is_done), 256'd0);
                    check("found_nonce", 256'(found_nonce), 256'(e.nonce));
                    check("found_hash", found_hash, e.hash);
                end
            end
            if (scan_done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_scan_done: scan_hit=%0d", scan_hit);
                end else begin
                    e = sb_q.pop_front();
                    check("event_kind_done", 256'(e.is_done), 256'd1);
                    check("scan_hit", 256'(scan_hit), 256'(e.hit));
                    check("busy_low_at_done", 256'(busy), 256'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic run_job(input logic [639:0] hdr, input logic [31:0] ns,
                           input logic [31:0] ne, input logic [255:0] tgt);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!job_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!job_ready) check("job_ready_timeout", 256'(job_ready), 256'd1);
        header      = hdr;
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        job_valid   = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        check("busy_after_accept", 256'(busy), 256'd1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!scan_done && cycles < 20000);
        if (!scan_done) check("scan_done_timeout", 256'(scan_done), 256'd1);
        @(negedge clk);
        check("scoreboard_drained", 256'(sb_q.size()), 256'd0);
    endtask

    task automatic wait_starts(input int count);
        int guard;
        guard = 0;
        while (cnt_start < count && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cnt_start < count) check("core_start_timeout", 256'(cnt_start), 256'(count));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_job_ready"},   256'(job_ready), 256'd1);
        check({tag, "_busy"},        256'(busy), 256'd0);
        check({tag, "_found_valid"}, 256'(found_valid), 256'd0);
        check({tag, "_found_nonce"}, 256'(found_nonce), 256'd0);
        check({tag, "_found_hash"},  found_hash, 256'd0);
        check({tag, "_scan_done"},   256'({scan_done, scan_hit}), 256'd0);
        check({tag, "_core_ctl"},    256'({core_start, core_use_iv}), 256'd0);
        check({tag, "_core_block"},  256'(|core_block), 256'd0);
        check({tag, "_core_iv"},     core_iv, 256'd0);
    endtask

    task automatic genesis_run(input string tag);
        int b_mid, b_blk2, b_outer, cyc;
        b_mid   = cnt_mid;
        b_blk2  = cnt_blk2;
        b_outer = cnt_outer;
        push_found(GEN_NONCE, GEN_HASH);
        push_done(1'b1);
        run_job(GEN_HDR, 32'h7C2BAC1A, 32'h7C2BAC20, GEN_TARGET);
        wait_done(cyc);
        check({tag, "_mid_ops"},   256'(cnt_mid - b_mid), 256'd1);
        check({tag, "_blk2_ops"},  256'(cnt_blk2 - b_blk2), 256'd4);
        check({tag, "_outer_ops"}, 256'(cnt_outer - b_outer), 256'd4);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int cyc, b_start, b_blk2, b_outer;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Genesis block: the winning nonce is the fourth in the range.
        genesis_run("genesis");

        // Impossible target: every nonce checked, no hit.
        b_blk2  = cnt_blk2;
        b_outer = cnt_outer;
        push_done(1'b0);
        run_job(GEN_HDR, 32'd0, 32'd3, 256'd0);
        wait_done(cyc);
        check("zero_target_blk2_ops", 256'(cnt_blk2 - b_blk2), 256'd4);
        check("zero_target_outer_ops", 256'(cnt_outer - b_outer), 256'd4);

        // Empty range: finishes quickly without touching the core.
        b_start = cnt_start;
        push_done(1'b0);
        run_job(GEN_HDR, 32'd5, 32'd4, GEN_TARGET);
        wait_done(cyc);
        check("empty_range_latency_ok", 256'(cyc <= 3), 256'd1);
        check("empty_range_no_core_ops", 256'(cnt_start - b_start), 256'd0);

        // Top of the nonce space, any hash hits.
        b_blk2 = cnt_blk2;
        push_found(32'hFFFFFFFF, sha256d_ref(GEN_HDR, 32'hFFFFFFFF));
        push_done(1'b1);
        run_job(GEN_HDR, 32'hFFFFFFFF, 32'hFFFFFFFF, {256{1'b1}});
        wait_done(cyc);
        check("top_nonce_blk2_ops", 256'(cnt_blk2 - b_blk2), 256'd1);

        // Range ending at 0xFFFFFFFF with no hit must stop there, not wrap.
        b_blk2 = cnt_blk2;
        push_done(1'b0);
        run_job(GEN_HDR, 32'hFFFFFFFE, 32'hFFFFFFFF, 256'd0);
        wait_done(cyc);
        repeat (20) @(negedge clk);
        check("no_wrap_blk2_ops", 256'(cnt_blk2 - b_blk2), 256'd2);
        check("no_wrap_idle", 256'(busy), 256'd0);

        // Abort during the second nonce's OUTER op (5th core op of the job).
        b_start = cnt_start;
        b_blk2  = cnt_blk2;
        b_outer = cnt_outer;
        push_done(1'b0);
        run_job(GEN_HDR, 32'd0, 32'd9, 256'd0);
        wait_starts(b_start + 5);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done(cyc);
        repeat (10) @(negedge clk);
        check("abort_total_ops", 256'(cnt_start - b_start), 256'd5);
        check("abort_blk2_ops", 256'(cnt_blk2 - b_blk2), 256'd2);
        check("abort_outer_ops", 256'(cnt_outer - b_outer), 256'd2);
        check("abort_core_released", 256'(core_done), 256'd0);
        genesis_run("after_abort");

        // Reset in the middle of the second nonce's BLK2 op.
        b_start = cnt_start;
        push_found(GEN_NONCE, GEN_HASH);
        push_done(1'b1);
        run_job(GEN_HDR, 32'h7C2BAC1A, 32'h7C2BAC20, GEN_TARGET);
        wait_starts(b_start + 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mid_reset");
        sb_q.delete();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_core_released", 256'(core_done), 256'd0);
        genesis_run("after_reset");

        check("scoreboard_empty_end", 256'(sb_q.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256d_nonce_scanner.md
Name: sha256d_nonce_scanner

Overview:
- Sequencer that owns one sha256_core instance and drives it through Bitcoin double-SHA256 over an 80-byte block header while sweeping a nonce range.
- Per job it computes the first-block midstate once. Per nonce it runs the second header block (chained IV) and then the outer hash (standard IV).
- It compares each result with a 256-bit target, reports the first hit, and sits between the job/UART front end and the core.

Parameters:
STOP_ON_FOUND, 1, 1 = end scan at first hit; 0 = report each hit (pulse) and continue to nonce_end

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
job_valid  in  1  job offered
job_ready  out  1  high only in IDLE; job accepted when job_valid & job_ready
header  in  640  serialized header, byte 0 at bits [639:632]; bytes 76..79 (nonce field) ignored
nonce_start  in  32  first nonce (numeric)
nonce_end  in  32  last nonce inclusive (numeric)
target  in  256  numeric target; hit when hash_num <= target
abort  in  1  abandon current scan
busy  out  1  high from job accept until scan_done
found_valid  out  1  1-cycle pulse on hit
found_nonce  out  32  numeric nonce of last hit, held until next hit or reset
found_hash  out  256  hash_num of last hit, held
scan_done  out  1  1-cycle pulse at scan end
scan_hit  out  1  valid with scan_done: at least one hit this job
core_start  out  1  to sha256_core.start
core_block  out  512  to sha256_core.block
core_use_iv  out  1  to sha256_core.use_iv
core_iv  out  256  to sha256_core.iv_in
core_done  in  1  from sha256_core.done
core_hash  in  256  from sha256_core.hash

Behaviour:
- Reset (any cycle, including mid-scan): state IDLE; all outputs 0 except job_ready=1. Latched job registers do not need reset. A core operation left in flight is recovered with the same RELEASE rule (core sees start=0 and returns idle).
- Accept: header, nonce_start, nonce_end and target are latched; the current nonce register n <= nonce_start. If nonce_start > nonce_end, go to FINISH with no core operations.
- States: IDLE -> MID -> BLK2 -> OUTER -> CHECK -> (BLK2 | FINISH); FINISH -> IDLE.
- Core op protocol, inside MID/BLK2/OUTER:
  - ISSUE: core_start=1, core_block/core_use_iv/core_iv stable; held until core_done=1.
  - Capture core_hash on that cycle.
  - RELEASE: core_start=0; wait until core_done=0 before leaving the state.
  - core_start is never reasserted while core_done=1.
- MID: block = header bytes 0..63, use_iv=0. Result is stored as midstate.
- BLK2: block = header bytes 64..75, then nonce bytes n[7:0], n[15:8], n[23:16], n[31:24], then 0x80, zeros, and 64-bit length 0x280. use_iv=1, iv=midstate.
- OUTER: block = BLK2 digest (256), then 0x80, zeros, and length 0x100. use_iv=0.
- hash_num = byte-reverse of the OUTER digest (digest byte 31 becomes the MSB).
- CHECK (1 cycle): unsigned compare hash_num <= target.
  - On a hit: found_valid pulse, found_nonce=n, found_hash=hash_num, hit flag set.
  - If (hit & STOP_ON_FOUND) or n==nonce_end: go to FINISH.
  - Otherwise n<=n+1 and go to BLK2.
  - n never wraps: nonce_end=0xFFFFFFFF ends after n=0xFFFFFFFF is checked.
- FINISH: scan_done pulse, scan_hit=hit flag, busy drops the same cycle, then IDLE.
- abort:
  - In ISSUE it takes effect at the next RELEASE completion. In all other non-IDLE states it takes effect immediately.
  - Goes to FINISH with scan_hit reflecting hits so far.
  - abort and a CHECK hit in the same cycle: the hit is reported first and scan_done follows.
- job_valid during busy: ignored, since job_ready=0.

Test Plan:
- Genesis header (version 01000000, prev 32×00, merkle 3ba3edfd…4b1e5e4a, time 29ab5f49, bits ffff001d), range 0x7C2BAC1A..0x7C2BAC20, target 0x00000000FFFF0000…0.
  - Required: one found_valid with found_nonce=0x7C2BAC1D and found_hash=0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
  - Required: exactly 4 BLK2 ops and 1 MID op, then scan_done with scan_hit=1.
- Same header, target=0, range 0..3: exactly 4 BLK2/OUTER pairs, no found_valid, scan_done with scan_hit=0.
- nonce_start=5, nonce_end=4: scan_done within 3 cycles of accept, core_start never asserted.
- nonce_start=nonce_end=0xFFFFFFFF, target all-ones: one hit with found_nonce=0xFFFFFFFF, scan ends, no wrap to 0.
- abort asserted during OUTER of the second nonce: core handshake completes cleanly (start low until done low), scan_done with scan_hit=0, next job accepted and produces correct results.
- rst pulse mid-BLK2: outputs zeroed and job_ready=1 the next cycle; a rerun of the genesis test passes afterwards.
